// File: rtl/chess_clock_if.sv
// chess_clock_if: button/time inputs and display/status outputs of the chess clock controller.
// Ports (signals):
//   newGame, pause, pressA, pressB  1-cycle command pulses into the controller
//   timeIn[5:0]                     initial minutes per player
//   setTime                         1 while the controller is in SETUP
//   countedTime[23:0]               {A_mm, A_ss, B_mm, B_ss}
//   turn, running, flagA, flagB     game status
// Modports: master drives the commands, slave is the controller.
interface chess_clock_if;
   logic        newGame;
   logic        pause;
   logic        pressA;
   logic        pressB;
   logic [5:0]  timeIn;
   logic        setTime;
   logic [23:0] countedTime;
   logic        turn;
   logic        running;
   logic        flagA;
   logic        flagB;
   modport master (
      output newGame, pause, pressA, pressB, timeIn,
      input  setTime, countedTime, turn, running, flagA, flagB
   );
   modport slave (
      input  newGame, pause, pressA, pressB, timeIn,
      output setTime, countedTime, turn, running, flagA, flagB
   );
endinterface

// File: rtl/chess_clock_ctrl.sv
// chess_clock_ctrl: chess timer game controller; holds both players' mm:ss, sequences turns,
// counts down the active player and detects flag fall.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    chess_clock_if.slave: command pulses and timeIn in; setTime, countedTime,
//          turn, running, flagA, flagB out (all registered)
// Parameters:
//   TICK_DIV  clk cycles per 1 s countdown tick
//   INC_S     seconds added to a player when they hand the turn over (0..59)
module chess_clock_ctrl #(
   parameter int TICK_DIV = 100_000_000,
   parameter int INC_S    = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   chess_clock_if.slave bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);
   typedef enum logic [2:0] {SETUP, RUN_A, RUN_B, PAUSE_A, PAUSE_B, FLAG} state_t;
   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [11:0]   a_q, a_d, b_q, b_d;
   logic          turn_q, turn_d;
   logic          flag_a_q, flag_a_d, flag_b_q, flag_b_d;
   logic          set_q, set_d, run_q, run_d;
   logic [5:0]    tmin;
   logic [11:0]   a_dec, b_dec;
   logic          tick;
   // Times are {mm[5:0], ss[5:0]}; 00:00 never decrements further.
   function automatic logic [11:0] dec_t(input logic [11:0] t);
      if (t == 12'd0) return 12'd0;
      return (t[5:0] == 6'd0) ? {t[11:6] - 6'd1, 6'd59} : {t[11:6], t[5:0] - 6'd1};
   endfunction
   // Increment carries at most once into minutes since INC_S < 60; saturates at 59:59.
   function automatic logic [11:0] inc_t(input logic [11:0] t);
      logic [6:0] s;
      logic [6:0] m;
      s = {1'b0, t[5:0]} + 7'(INC_S);
      m = {1'b0, t[11:6]} + ((s >= 7'd60) ? 7'd1 : 7'd0);
      s = (s >= 7'd60) ? s - 7'd60 : s;
      return (m > 7'd59) ? {6'd59, 6'd59} : {m[5:0], s[5:0]};
   endfunction
   always_comb begin
      tmin     = (bus.timeIn > 6'd59) ? 6'd59 : bus.timeIn;
      tick     = presc_q == TC;
      a_dec    = dec_t(a_q);
      b_dec    = dec_t(b_q);
      state_d  = state_q;
      presc_d  = presc_q;
      a_d      = a_q;
      b_d      = b_q;
      turn_d   = turn_q;
      flag_a_d = flag_a_q;
      flag_b_d = flag_b_q;
      if (bus.newGame) begin
         state_d  = SETUP;
         presc_d  = '0;
         turn_d   = 1'b0;
         flag_a_d = 1'b0;
         flag_b_d = 1'b0;
      end else begin
         case (state_q)
            SETUP: begin
               a_d = {tmin, 6'd0};
               b_d = {tmin, 6'd0};
               // Exactly one press with a non-zero start time starts the other player's clock.
               if (tmin != 6'd0 && (bus.pressA ^ bus.pressB)) begin
                  state_d = bus.pressA ? RUN_B : RUN_A;
                  turn_d  = bus.pressA;
                  presc_d = '0;
               end
            end
            RUN_A: begin
               if (bus.pause) state_d = PAUSE_A;
               else begin
                  presc_d = tick ? '0 : presc_q + 1'b1;
                  a_d     = tick ? a_dec : a_q;
                  // Flag fall outranks a hand-off landing on the same tick.
                  if (tick && a_dec == 12'd0) begin
                     state_d  = FLAG;
                     flag_a_d = 1'b1;
                  end else if (bus.pressA) begin
                     a_d     = inc_t(a_d);
                     state_d = RUN_B;
                     turn_d  = 1'b1;
                     presc_d = '0;
                  end
               end
            end
            RUN_B: begin
               if (bus.pause) state_d = PAUSE_B;
               else begin
                  presc_d = tick ? '0 : presc_q + 1'b1;
                  b_d     = tick ? b_dec : b_q;
                  if (tick && b_dec == 12'd0) begin
                     state_d  = FLAG;
                     flag_b_d = 1'b1;
                  end else if (bus.pressB) begin
                     b_d     = inc_t(b_d);
                     state_d = RUN_A;
                     turn_d  = 1'b0;
                     presc_d = '0;
                  end
               end
            end
            PAUSE_A: state_d = bus.pause ? RUN_A : PAUSE_A;
            PAUSE_B: state_d = bus.pause ? RUN_B : PAUSE_B;
            FLAG:    state_d = FLAG;
            default: state_d = SETUP;
         endcase
      end
      set_d = state_d == SETUP;
      run_d = (state_d == RUN_A) || (state_d == RUN_B);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= SETUP;
         presc_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         turn_q   <= 1'b0;
         flag_a_q <= 1'b0;
         flag_b_q <= 1'b0;
         set_q    <= 1'b1;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         turn_q   <= turn_d;
         flag_a_q <= flag_a_d;
         flag_b_q <= flag_b_d;
         set_q    <= set_d;
         run_q    <= run_d;
      end
   end
   assign bus.setTime     = set_q;
   assign bus.countedTime = {a_q, b_q};
   assign bus.turn        = turn_q;
   assign bus.running     = run_q;
   assign bus.flagA       = flag_a_q;
   assign bus.flagB       = flag_b_q;
endmodule

// File: tb/tb_chess_clock_ctrl.sv
// tb_chess_clock_ctrl: self-checking bench for chess_clock_ctrl with TICK_DIV=4, INC_S=5.
// A seconds-based game model is compared against every output on each falling edge;
// directed literal checkpoints pin the model to hand-computed values.
module tb_chess_clock_ctrl;
   localparam int TD  = 4;
   localparam int INC = 5;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   chess_clock_if ifc();
   chess_clock_ctrl #(.TICK_DIV(TD), .INC_S(INC)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   // Model: mode 0 setup, 1 running, 2 paused, 3 flag; times held as total seconds.
   int m_mode = 0, m_act = 0, m_ph = 0;
   int m_t[2] = '{0, 0};
   bit m_fl[2] = '{1'b0, 1'b0};
   int n_mode, n_act, n_ph, n_cl;
   int n_t[2];
   bit n_fl[2];
   bit n_tick, n_press;
   always @(posedge clk) begin
      n_mode = m_mode;
      n_act  = m_act;
      n_ph   = m_ph;
      n_t    = m_t;
      n_fl   = m_fl;
      n_cl   = (ifc.timeIn > 6'd59) ? 59 : int'(ifc.timeIn);
      if (!rst_n) begin
         n_mode = 0;
         n_act  = 0;
         n_ph   = 0;
         n_t    = '{0, 0};
         n_fl   = '{1'b0, 1'b0};
      end else if (ifc.newGame) begin
         n_mode = 0;
         n_act  = 0;
         n_ph   = 0;
         n_fl   = '{1'b0, 1'b0};
      end else if (n_mode == 0) begin
         n_t = '{n_cl * 60, n_cl * 60};
         if (n_cl > 0 && ifc.pressA != ifc.pressB) begin
            n_mode = 1;
            n_act  = ifc.pressA ? 1 : 0;
            n_ph   = 0;
         end
      end else if (n_mode == 1) begin
         if (ifc.pause) n_mode = 2;
         else begin
            n_ph++;
            n_tick = n_ph == TD;
            if (n_tick) begin
               n_ph = 0;
               n_t[n_act]--;
            end
            n_press = (n_act == 0) ? ifc.pressA : ifc.pressB;
            if (n_tick && n_t[n_act] == 0) begin
               n_mode       = 3;
               n_fl[n_act]  = 1'b1;
            end else if (n_press) begin
               n_t[n_act] = (n_t[n_act] + INC > 3599) ? 3599 : n_t[n_act] + INC;
               n_act      = 1 - n_act;
               n_ph       = 0;
            end
         end
      end else if (n_mode == 2) begin
         if (ifc.pause) n_mode = 1;
      end
      m_mode <= n_mode;
      m_act  <= n_act;
      m_ph   <= n_ph;
      m_t    <= n_t;
      m_fl   <= n_fl;
   end
   logic [28:0] obs;
   assign obs = {ifc.setTime, ifc.running, ifc.turn, ifc.flagA, ifc.flagB, ifc.countedTime};
   string       pin_nm;
   logic [28:0] pin_mask, pin_exp;
   int          pin_cnt = 0;
   int          pin_seen = 0;
   function automatic int bad(input string nm, input int got, input int exp);
      if (got != exp) $display("FAIL %s got %0d exp %0d", nm, got, exp);
      return (got != exp) ? 1 : 0;
   endfunction
   function automatic logic [23:0] ct(input int ta, input int tb);
      return {6'(ta / 60), 6'(ta % 60), 6'(tb / 60), 6'(tb % 60)};
   endfunction
   int c, e;
   always @(negedge clk) begin
      c = 0;
      e = 0;
      if (chk_en) begin
         c += 6;
         e += bad("setTime", int'(ifc.setTime), (m_mode == 0) ? 1 : 0);
         e += bad("running", int'(ifc.running), (m_mode == 1) ? 1 : 0);
         e += bad("turn", int'(ifc.turn), m_act);
         e += bad("flagA", int'(ifc.flagA), int'(m_fl[0]));
         e += bad("flagB", int'(ifc.flagB), int'(m_fl[1]));
         e += bad("countedTime", int'(ifc.countedTime), int'(ct(m_t[0], m_t[1])));
      end
      if (pin_cnt != pin_seen) begin
         c += 1;
         if ((obs & pin_mask) != (pin_exp & pin_mask)) begin
            e += 1;
            $display("FAIL pin %s got %h exp %h", pin_nm, obs & pin_mask, pin_exp & pin_mask);
         end
      end
      pin_seen <= pin_cnt;
      checks   <= checks + c;
      errors   <= errors + e;
   end
   localparam logic [28:0] ALL   = '1;
   localparam logic [28:0] NO_CT = {5'h1f, 24'h0};
   function automatic logic [28:0] ov(input bit st, input bit run, input bit tu, input bit fa,
                                      input bit fb, input logic [5:0] am, input logic [5:0] as_,
                                      input logic [5:0] bm, input logic [5:0] bs);
      return {st, run, tu, fa, fb, am, as_, bm, bs};
   endfunction
   task automatic pin(input string nm, input logic [28:0] mask, input logic [28:0] exp);
      pin_nm   = nm;
      pin_mask = mask;
      pin_exp  = exp;
      pin_cnt++;
      @(negedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic pulse(input bit ng, input bit pa, input bit pr_a, input bit pr_b);
      ifc.newGame = ng;
      ifc.pause   = pa;
      ifc.pressA  = pr_a;
      ifc.pressB  = pr_b;
      @(posedge clk);
      #1;
      ifc.newGame = 1'b0;
      ifc.pause   = 1'b0;
      ifc.pressA  = 1'b0;
      ifc.pressB  = 1'b0;
   endtask
   initial begin
      ifc.newGame = 1'b0;
      ifc.pause   = 1'b0;
      ifc.pressA  = 1'b0;
      ifc.pressB  = 1'b0;
      ifc.timeIn  = 6'd5;
      idle(3);
      chk_en = 1'b1;
      pin("reset", ALL, ov(1, 0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b1;
      idle(1);
      pin("setup_load", ALL, ov(1, 0, 0, 0, 0, 5, 0, 5, 0));
      pulse(0, 0, 1, 0);
      pin("start_b", ALL, ov(0, 1, 1, 0, 0, 5, 0, 5, 0));
      idle(4);
      pin("b_first_tick", ALL, ov(0, 1, 1, 0, 0, 5, 0, 4, 59));
      idle(4 * 299);
      pin("b_flag", ALL, ov(0, 0, 1, 0, 1, 5, 0, 0, 0));
      idle(10);
      pin("flag_frozen", ALL, ov(0, 0, 1, 0, 1, 5, 0, 0, 0));
      ifc.timeIn = 6'd1;
      pulse(1, 0, 0, 0);
      idle(1);
      pulse(0, 0, 0, 1);
      idle(8);
      pin("a_at_0058", ALL, ov(0, 1, 0, 0, 0, 0, 58, 1, 0));
      pulse(0, 0, 1, 0);
      pin("inc_carry", ALL, ov(0, 1, 1, 0, 0, 1, 3, 1, 0));
      pulse(0, 0, 1, 0);
      pin("inactive_press", ALL, ov(0, 1, 1, 0, 0, 1, 3, 1, 0));
      ifc.timeIn = 6'd63;
      pulse(1, 0, 0, 0);
      idle(1);
      pin("clamp63", ALL, ov(1, 0, 0, 0, 0, 59, 0, 59, 0));
      pulse(0, 0, 0, 1);
      idle(12);
      pin("a_5857", ALL, ov(0, 1, 0, 0, 0, 58, 57, 59, 0));
      repeat (12) begin
         pulse(0, 0, 1, 0);
         pulse(0, 0, 0, 1);
      end
      pin("a_5957", ALL, ov(0, 1, 0, 0, 0, 59, 57, 59, 59));
      pulse(0, 0, 1, 0);
      pin("saturate", ALL, ov(0, 1, 1, 0, 0, 59, 59, 59, 59));
      ifc.timeIn = 6'd5;
      pulse(1, 0, 0, 0);
      idle(1);
      pulse(0, 1, 0, 0);
      pulse(0, 0, 1, 1);
      pin("setup_ignores", ALL, ov(1, 0, 0, 0, 0, 5, 0, 5, 0));
      pulse(0, 0, 0, 1);
      idle(2);
      pulse(0, 1, 0, 0);
      pin("paused", ALL, ov(0, 0, 0, 0, 0, 5, 0, 5, 0));
      idle(20);
      pulse(0, 0, 1, 0);
      pin("pause_hold", ALL, ov(0, 0, 0, 0, 0, 5, 0, 5, 0));
      pulse(0, 1, 0, 0);
      pin("resume", ALL, ov(0, 1, 0, 0, 0, 5, 0, 5, 0));
      idle(1);
      pin("resume_pre", ALL, ov(0, 1, 0, 0, 0, 5, 0, 5, 0));
      idle(1);
      pin("resume_tick", ALL, ov(0, 1, 0, 0, 0, 4, 59, 5, 0));
      ifc.timeIn = 6'd1;
      pulse(1, 0, 0, 0);
      idle(1);
      pulse(0, 0, 0, 1);
      idle(4 * 59 + 3);
      pin("a_at_0001", ALL, ov(0, 1, 0, 0, 0, 0, 1, 1, 0));
      pulse(0, 0, 1, 0);
      pin("timeout_wins", ALL, ov(0, 0, 0, 1, 0, 0, 0, 1, 0));
      pulse(1, 0, 0, 0);
      pin("newgame", NO_CT, ov(1, 0, 0, 0, 0, 0, 0, 0, 0));
      idle(1);
      pin("newgame_load", ALL, ov(1, 0, 0, 0, 0, 1, 0, 1, 0));
      ifc.timeIn = 6'd0;
      idle(1);
      pulse(0, 0, 1, 0);
      pin("zero_time_press", ALL, ov(1, 0, 0, 0, 0, 0, 0, 0, 0));
      idle(2);
      pin("zero_time_stay", ALL, ov(1, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
